scarv_cop_rng_pool: RTL and testbench

Entropy-pool stage directly upstream of the COP random number unit. Holds a 32-bit Galois LFSR that free-runs, harvests one word every HARVEST_STEPS steps into a 2-entry buffer, and presents buffered words to the RNG instruction unit over a valid/ready handshake. Also accepts seed writes (rng.seed path), which mix into the state and flush stale words, and runs a sticky repetition health test on harvested words.

---
 rtl/scarv_cop_rng_pool.sv | 134 +++++++++++++
 tb/tb_scarv_cop_rng_pool.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_rng_pool.sv
// Entropy pool: free-running 32-bit Galois LFSR harvested into a 2-entry buffer,
// with seed mixing/flush and a sticky repetition health test on harvested words.
module scarv_cop_rng_pool #(
   parameter logic [31:0] RESET_SEED    = 32'hACE1_2468,
   parameter int          HARVEST_STEPS = 32
) (
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic        seed_valid,
   input  logic [31:0] seed_data,
   output logic        samp_valid,
   input  logic        samp_ready,
   output logic [31:0] samp_data,
   output logic        seeded,
   output logic        health_fail,
   output logic [1:0]  pool_level
);

   localparam logic [7:0] LAST_CNT = 8'(HARVEST_STEPS - 1);

   logic [31:0] state_reg, state_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic [31:0] head_reg, head_next;
   logic [31:0] tail_reg, tail_next;
   logic [1:0]  level_reg, level_next;
   logic [31:0] last_reg, last_next;
   logic        seeded_reg, seeded_next;
   logic        health_reg, health_next;

   logic [31:0] stepped;
   logic [31:0] mixed;
   logic        running;
   logic        push;
   logic        pop;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   always_comb begin
      stepped = lfsr_step(state_reg);
      mixed   = stepped ^ seed_data;
      running = (level_reg != 2'd2);
      pop     = (level_reg != 2'd0) && samp_ready;
      push    = running && (cnt_reg == LAST_CNT) && !seed_valid;

      state_next  = state_reg;
      cnt_next    = cnt_reg;
      head_next   = head_reg;
      tail_next   = tail_reg;
      level_next  = level_reg;
      last_next   = last_reg;
      seeded_next = seeded_reg;
      health_next = health_reg;

      if (seed_valid) begin
         // A zero state would lock the LFSR, so fall back to the reset seed.
         state_next  = (mixed == 32'h0) ? RESET_SEED : mixed;
         cnt_next    = 8'd0;
         head_next   = 32'h0;
         tail_next   = 32'h0;
         level_next  = 2'd0;
         last_next   = 32'h0;
         seeded_next = 1'b1;
         health_next = 1'b0;
      end else begin
         if (running) begin
            state_next = stepped;
            cnt_next   = push ? 8'd0 : cnt_reg + 8'd1;
         end
         if (push) begin
            last_next = stepped;
            if (stepped == last_reg)
               health_next = 1'b1;
         end
         case (level_reg)
            2'd0: begin
               if (push) begin
                  head_next  = stepped;
                  level_next = 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  head_next = stepped;
               end else if (pop) begin
                  head_next  = 32'h0;
                  level_next = 2'd0;
               end else if (push) begin
                  tail_next  = stepped;
                  level_next = 2'd2;
               end
            end
            2'd2: begin
               if (pop) begin
                  head_next  = tail_reg;
                  tail_next  = 32'h0;
                  level_next = 2'd1;
               end
            end
            default: level_next = 2'd0;
         endcase
      end
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state_reg  <= RESET_SEED;
         cnt_reg    <= 8'd0;
         head_reg   <= 32'h0;
         tail_reg   <= 32'h0;
         level_reg  <= 2'd0;
         last_reg   <= 32'h0;
         seeded_reg <= 1'b0;
         health_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         head_reg   <= head_next;
         tail_reg   <= tail_next;
         level_reg  <= level_next;
         last_reg   <= last_next;
         seeded_reg <= seeded_next;
         health_reg <= health_next;
      end
   end

   assign samp_valid  = (level_reg != 2'd0);
   assign samp_data   = head_reg;
   assign seeded      = seeded_reg;
   assign health_fail = health_reg;
   assign pool_level  = level_reg;

endmodule

// File: tb/tb_scarv_cop_rng_pool.sv
// Bench for scarv_cop_rng_pool: default-parameter instance (a) and a
// RESET_SEED=1 / HARVEST_STEPS=1 instance (b), with per-instance pop scoreboards.
module tb_scarv_cop_rng_pool;

   localparam logic [31:0] SEED_A = 32'hACE1_2468;
   localparam logic [31:0] SEED_B = 32'h0000_0001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_reset, a_seed_valid, a_ready, a_valid, a_seeded, a_health;
   logic [31:0] a_seed_data, a_data;
   logic [1:0]  a_level;
   logic        b_reset, b_seed_valid, b_ready, b_valid, b_seeded, b_health;
   logic [31:0] b_seed_data, b_data;
   logic [1:0]  b_level;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] qa[$];
   logic [31:0] qb[$];

   scarv_cop_rng_pool u_a (
      .g_clk(clk), .g_reset(a_reset), .seed_valid(a_seed_valid), .seed_data(a_seed_data),
      .samp_valid(a_valid), .samp_ready(a_ready), .samp_data(a_data),
      .seeded(a_seeded), .health_fail(a_health), .pool_level(a_level)
   );

   scarv_cop_rng_pool #(.RESET_SEED(SEED_B), .HARVEST_STEPS(1)) u_b (
      .g_clk(clk), .g_reset(b_reset), .seed_valid(b_seed_valid), .seed_data(b_seed_data),
      .samp_valid(b_valid), .samp_ready(b_ready), .samp_data(b_data),
      .seeded(b_seeded), .health_fail(b_health), .pool_level(b_level)
   );

   function automatic logic [31:0] step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   function automatic logic [31:0] stepn(input logic [31:0] s, input int n);
      logic [31:0] r = s;
      for (int i = 0; i < n; i++) r = step(r);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitors: a handshake is sampled mid-cycle and matched to the queue head.
   always @(negedge clk) begin
      if (a_valid && a_ready) begin
         if (qa.size() == 0) check("a_pop_unexpected", a_data, 32'hxxxx_xxxx);
         else begin
            logic [31:0] e;
            e = qa.pop_front();
            $display("a pop data=%h expect=%h", a_data, e);
            check("a_pop", a_data, e);
         end
      end
      if (b_valid && b_ready) begin
         if (qb.size() == 0) check("b_pop_unexpected", b_data, 32'hxxxx_xxxx);
         else begin
            logic [31:0] e;
            e = qb.pop_front();
            $display("b pop data=%h expect=%h", b_data, e);
            check("b_pop", b_data, e);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w1, w2, w3, w4, nw, n32, dd;
      a_reset = 1'b1; a_seed_valid = 1'b0; a_seed_data = 32'h0; a_ready = 1'b0;
      b_reset = 1'b1; b_seed_valid = 1'b0; b_seed_data = 32'h0; b_ready = 1'b0;
      w1 = stepn(SEED_A, 32);
      w2 = stepn(SEED_A, 64);
      w3 = stepn(SEED_A, 96);
      w4 = stepn(SEED_A, 128);

      // Reset state
      repeat (2) tick();
      check("a_rst_valid", 32'(a_valid), 32'd0);
      check("a_rst_level", 32'(a_level), 32'd0);
      check("a_rst_data", a_data, 32'h0);
      check("a_rst_seeded", 32'(a_seeded), 32'd0);
      check("a_rst_health", 32'(a_health), 32'd0);
      check("b_rst_valid", 32'(b_valid), 32'd0);

      // First-word latency and fill-to-full with no consumer
      a_reset = 1'b0;
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (k == 31) check("a_lat_valid31", 32'(a_valid), 32'd0);
         if (k == 32) begin
            check("a_lat_valid32", 32'(a_valid), 32'd1);
            check("a_first_word", a_data, w1);
         end
         if (k == 63) check("a_level63", 32'(a_level), 32'd1);
         if (k == 64) check("a_level64", 32'(a_level), 32'd2);
      end
      repeat (10) tick();
      check("a_full_level", 32'(a_level), 32'd2);
      check("a_full_head", a_data, w1);

      // Single pop from full; LFSR must have been frozen while full
      qa.push_back(w1);
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      check("a_pop_level", 32'(a_level), 32'd1);
      check("a_pop_head", a_data, w2);
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (k == 31) check("a_refill31", 32'(a_level), 32'd1);
         if (k == 32) check("a_refill32", 32'(a_level), 32'd2);
      end
      qa.push_back(w2);
      qa.push_back(w3);
      a_ready = 1'b1;
      tick();
      tick();
      a_ready = 1'b0;
      check("a_drain_level", 32'(a_level), 32'd0);
      check("a_drain_valid", 32'(a_valid), 32'd0);
      check("a_drain_data", a_data, 32'h0);
      repeat (31) tick();
      check("a_w4_level", 32'(a_level), 32'd1);
      check("a_w4_head", a_data, w4);
      repeat (32) tick();
      check("a_w5_level", 32'(a_level), 32'd2);

      // Seed while full with a pop in the same cycle
      dd = 32'h1234_5678;
      qa.push_back(w4);
      a_ready = 1'b1; a_seed_valid = 1'b1; a_seed_data = dd;
      tick();
      a_ready = 1'b0; a_seed_valid = 1'b0;
      check("a_seed_level", 32'(a_level), 32'd0);
      check("a_seed_data0", a_data, 32'h0);
      check("a_seed_seeded", 32'(a_seeded), 32'd1);
      nw  = step(stepn(SEED_A, 160)) ^ dd;
      n32 = stepn(nw, 32);
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (k == 31) check("a_seed_lat31", 32'(a_valid), 32'd0);
         if (k == 32) begin
            check("a_seed_lat32", 32'(a_valid), 32'd1);
            check("a_seed_word", a_data, n32);
         end
      end

      // Seed that cancels the next state: LFSR falls back to RESET_SEED
      a_seed_valid = 1'b1; a_seed_data = step(n32);
      tick();
      a_seed_valid = 1'b0;
      check("a_zero_seed_level", 32'(a_level), 32'd0);
      repeat (32) tick();
      check("a_zero_seed_word", a_data, w1);
      check("a_zero_seed_nonzero", 32'(a_data != 32'h0), 32'd1);
      repeat (32) tick();
      check("a_zero_seed_full", 32'(a_level), 32'd2);

      // Asynchronous reset in the middle of a handshake
      a_ready = 1'b1; a_reset = 1'b1;
      #1;
      check("a_async_valid", 32'(a_valid), 32'd0);
      check("a_async_level", 32'(a_level), 32'd0);
      check("a_async_data", a_data, 32'h0);
      check("a_async_seeded", 32'(a_seeded), 32'd0);
      tick();
      a_ready = 1'b0; a_reset = 1'b0;
      repeat (32) tick();
      check("a_post_rst_valid", 32'(a_valid), 32'd1);
      check("a_post_rst_word", a_data, w1);

      // HARVEST_STEPS=1: one word per cycle, continuous valid
      for (int k = 1; k <= 7; k++) qb.push_back(stepn(SEED_B, k));
      b_ready = 1'b1; b_reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("b_stream_valid", 32'(b_valid), 32'd1);
         check("b_stream_word", b_data, stepn(SEED_B, k));
      end
      b_ready = 1'b0;
      tick();
      check("b_full_level", 32'(b_level), 32'd2);

      // Force the LFSR into its all-zero fixed point to get repeated harvests
      force u_b.state_reg = 32'h0;
      qb.push_back(stepn(SEED_B, 8));
      qb.push_back(stepn(SEED_B, 9));
      qb.push_back(32'h0);
      qb.push_back(32'h0);
      b_ready = 1'b1;
      tick();
      tick();
      check("b_health_first0", 32'(b_health), 32'd0);
      tick();
      check("b_health_set", 32'(b_health), 32'd1);
      tick();
      b_ready = 1'b0;
      check("b_health_sticky", 32'(b_health), 32'd1);
      release u_b.state_reg;
      repeat (2) tick();
      check("b_health_hold", 32'(b_health), 32'd1);
      b_seed_valid = 1'b1; b_seed_data = 32'h0000_00F0;
      tick();
      b_seed_valid = 1'b0;
      check("b_seed_health", 32'(b_health), 32'd0);
      check("b_seed_level", 32'(b_level), 32'd0);
      check("b_seed_seeded", 32'(b_seeded), 32'd1);
      tick();
      check("b_seed_lat", 32'(b_valid), 32'd1);

      tick();
      check("a_queue_empty", 32'(qa.size()), 32'd0);
      check("b_queue_empty", 32'(qb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
